// File: rtl/riscv_pkg.sv
// Shared widths and constants for the RISC-V front end.
package riscv_pkg;
  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;
  localparam int CNT_W      = 32;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  localparam int IFID_PC_W    = XLEN;
  localparam int IFID_INST_W  = ILEN;

  typedef struct packed {
    logic [IFID_PC_W-1:0]   pc;
    logic [IFID_INST_W-1:0] inst;
    logic                   valid;
  } if_id_t;
endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: reset > squash > load > hold.
module if_id_register
  import riscv_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   squash_i,
  input  if_id_t d_i,
  output if_id_t q_o
);
  if_id_t entry_q, entry_d;

  localparam if_id_t BUBBLE = '{pc: '0, inst: NOP_INST, valid: 1'b0};

  always_comb begin
    entry_d = entry_q;
    if (squash_i)    entry_d = BUBBLE;
    else if (load_i) entry_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (reset) entry_q <= BUBBLE;
    else       entry_q <= entry_d;
  end

  assign q_o = entry_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, next-PC selection, fault/fetch bookkeeping, IF/ID.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter logic [ILEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [ILEN-1:0]  Instruction,
  output logic [XLEN-1:0]  Inst_Address,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [ILEN-1:0]  if_id_instruction,
  output logic             if_id_valid,
  output logic             misaligned_fault,
  output logic [CNT_W-1:0] fetch_count
);
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, squash;
  if_id_t           ifid_d, ifid_q;

  // Priority: redirect beats flush beats stall; stall freezes everything.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    squash  = 1'b0;
    if (branch_taken) begin
      pc_d   = {branch_target[XLEN-1:2], 2'b00};
      squash = 1'b1;
      if (branch_target[1:0] != 2'b00) fault_d = 1'b1;
    end else if (flush) begin
      pc_d   = pc_q + XLEN'(INST_BYTES);
      squash = 1'b1;
    end else if (!stall) begin
      pc_d  = pc_q + XLEN'(INST_BYTES);
      load  = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ifid_d = '{pc: pc_q, inst: Instruction, valid: 1'b1};

  if_id_register #(.NOP_INST(NOP_INST)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .squash_i (squash),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

  assign Inst_Address      = pc_q;
  assign if_id_pc          = ifid_q.pc;
  assign if_id_instruction = ifid_q.inst;
  assign if_id_valid       = ifid_q.valid;
  assign misaligned_fault  = fault_q;
  assign fetch_count       = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Fetch unit bench: directed scenarios plus random traffic against a behavioural model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken;
  logic [63:0] branch_target;
  logic [31:0] Instruction;
  logic [63:0] Inst_Address, if_id_pc;
  logic [31:0] if_id_instruction, fetch_count;
  logic        if_id_valid, misaligned_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  assign Instruction = mem[Inst_Address[7:2]];

  instruction_fetch_unit #(.RESET_PC(64'h0), .NOP_INST(NOP)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .Instruction       (Instruction),
    .Inst_Address      (Inst_Address),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .misaligned_fault  (misaligned_fault),
    .fetch_count       (fetch_count)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_inst, m_cnt;
  logic        m_valid, m_fault;

  logic [193:0] act;
  assign act = {Inst_Address, if_id_pc, if_id_instruction, if_id_valid, misaligned_fault, fetch_count};

  function automatic logic [193:0] exp_vec();
    return {m_pc, m_ifpc, m_inst, m_valid, m_fault, m_cnt};
  endfunction

  // Drives one cycle of inputs, advances the model, returns #1 after the edge.
  task automatic step(input logic rs, input logic br, input logic fl, input logic st,
                      input logic [63:0] tgt);
    reset = rs; branch_taken = br; flush = fl; stall = st; branch_target = tgt;
    if (rs) begin
      m_pc = 64'h0; m_ifpc = 64'h0; m_inst = NOP; m_valid = 1'b0; m_fault = 1'b0; m_cnt = 0;
    end else if (br) begin
      m_ifpc = 64'h0; m_inst = NOP; m_valid = 1'b0;
      if (tgt % 4 != 0) m_fault = 1'b1;
      m_pc = tgt - (tgt % 4);
    end else if (fl) begin
      m_ifpc = 64'h0; m_inst = NOP; m_valid = 1'b0;
      m_pc = m_pc + 4;
    end else if (!st) begin
      m_ifpc = m_pc; m_inst = mem[m_pc[7:2]]; m_valid = 1'b1;
      m_cnt = m_cnt + 1;
      m_pc = m_pc + 4;
    end
    @(posedge clk); #1;
    reset = 1'b0; branch_taken = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_state act=%h exp=%h", act, exp_vec());
    end
    checks++;
    if ({Inst_Address, if_id_valid, if_id_instruction, fetch_count} !== {64'h0, 1'b0, NOP, 32'h0}) begin
      errors++; $display("FAIL reset_const pc=%h valid=%b inst=%h cnt=%0d", Inst_Address, if_id_valid, if_id_instruction, fetch_count);
    end
  endtask

  task automatic test_sequential();
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (Inst_Address !== 64'(4 * k)) begin
        errors++; $display("FAIL seq_pc k=%0d act=%h exp=%h", k, Inst_Address, 64'(4 * k));
      end
      if (k == 1) begin
        checks++;
        if ({if_id_pc, if_id_instruction, if_id_valid} !== {64'h0, 32'h0030_0293, 1'b1}) begin
          errors++; $display("FAIL seq_first_ifid pc=%h inst=%h valid=%b", if_id_pc, if_id_instruction, if_id_valid);
        end
      end
    end
    checks++;
    if (fetch_count !== 32'd4) begin
      errors++; $display("FAIL seq_count act=%0d exp=4", fetch_count);
    end
  endtask

  task automatic test_stall();
    logic [97:0] held;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    held = {if_id_pc, if_id_instruction, if_id_valid, fetch_count[0]};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (Inst_Address !== 64'h8 || {if_id_pc, if_id_instruction, if_id_valid, fetch_count[0]} !== held
          || fetch_count !== 32'd2) begin
        errors++; $display("FAIL stall_hold k=%0d pc=%h cnt=%0d ifid_pc=%h", k, Inst_Address, fetch_count, if_id_pc);
      end
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (Inst_Address !== 64'hC || act !== exp_vec()) begin
      errors++; $display("FAIL stall_release act=%h exp=%h", act, exp_vec());
    end
  endtask

  task automatic test_branch_priority();
    logic [31:0] cnt0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    cnt0 = fetch_count;
    step(0, 1, 1, 1, 64'h40);
    checks++;
    if ({Inst_Address, if_id_valid, if_id_instruction, fetch_count} !== {64'h40, 1'b0, NOP, cnt0}) begin
      errors++; $display("FAIL branch_prio pc=%h valid=%b inst=%h cnt=%0d exp_cnt=%0d", Inst_Address, if_id_valid, if_id_instruction, fetch_count, cnt0);
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL flush_only act=%h exp=%h", act, exp_vec());
    end
  endtask

  task automatic test_misaligned();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 64'h46);
    checks++;
    if (Inst_Address !== 64'h44 || misaligned_fault !== 1'b1) begin
      errors++; $display("FAIL misaligned pc=%h fault=%b exp pc=44 fault=1", Inst_Address, misaligned_fault);
    end
    for (int k = 0; k < 10; k++) begin
      step(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1), {56'h0, 6'($urandom()), 2'b00});
      checks++;
      if (misaligned_fault !== 1'b1 || act !== exp_vec()) begin
        errors++; $display("FAIL fault_sticky k=%0d act=%h exp=%h", k, act, exp_vec());
      end
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (misaligned_fault !== 1'b0) begin
      errors++; $display("FAIL fault_clear act=%b exp=0", misaligned_fault);
    end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 0);
    checks++;
    if (Inst_Address !== 64'h0 || if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || misaligned_fault !== 1'b0) begin
      errors++; $display("FAIL pc_wrap pc=%h ifid_pc=%h fault=%b", Inst_Address, if_id_pc, misaligned_fault);
    end
  endtask

  task automatic test_reset_mid_stall();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 64'h1C);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (Inst_Address !== 64'h20) begin
      errors++; $display("FAIL pre_reset_pc act=%h exp=20", Inst_Address);
    end
    step(1, 1, 1, 1, 64'h88);
    checks++;
    if (act !== {64'h0, 64'h0, NOP, 1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_mid_stall act=%h", act);
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      logic [63:0] tgt;
      tgt = ($urandom_range(0, 9) == 0) ? {32'hFFFF_FFFF, $urandom()} : {56'h0, 8'($urandom())};
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0), tgt);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random k=%0d act=%h exp=%h", k, act, exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    mem[0] = 32'h0030_0293;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_pc = 0; m_ifpc = 0; m_inst = NOP; m_valid = 0; m_fault = 0; m_cnt = 0;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_priority();
    test_misaligned();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
